// File: rtl/jump_addr_sequencer.sv
// Two-operand GOTO/CALL sequencer: fetches the J1/J2 address bytes, tests the branch
// condition against the ALU flags and reloads the program counter (optionally saving XY).
module jump_addr_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_inc,
  input  logic              start,
  input  logic [3:0]        cond,
  input  logic              call,
  input  logic              flag_s,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] bus_data,
  output logic              ld_j1,
  input  logic [DATA_W-1:0] j1_content,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] xy_data,
  output logic              xy_we,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_HI = 3'd1,
    S_LD_HI  = 3'd2,
    S_REQ_LO = 3'd3,
    S_EVAL   = 3'd4
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cond;
  logic                r_call;
  logic [DATA_W-1:0]   r_j2;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_req;
  logic [DATA_W-1:0]   r_bus_data;
  logic                r_ld_j1;
  logic [ADDR_W-1:0]   r_xy_data;
  logic                r_xy_we;
  logic                r_busy;
  logic                r_done;
  logic                r_taken;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_pc_next;

  // An all-zero condition field means an unconditional branch.
  assign w_taken = (r_cond == 4'b0000)
                 | (r_cond[3] & flag_s)
                 | (r_cond[2] & flag_c)
                 | (r_cond[1] & flag_z)
                 | (r_cond[0] & ~flag_z);

  assign w_pc_next = r_pc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cond     <= '0;
      r_call     <= 1'b0;
      r_j2       <= '0;
      r_pc       <= '0;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_bus_data <= '0;
      r_ld_j1    <= 1'b0;
      r_xy_data  <= '0;
      r_xy_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_taken    <= 1'b0;
    end else begin
      r_ld_j1 <= 1'b0;
      r_xy_we <= 1'b0;
      r_done  <= 1'b0;
      r_taken <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cond     <= cond;
            r_call     <= call;
            r_mem_addr <= r_pc;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_REQ_HI;
          end else if (pc_inc) begin
            r_pc <= w_pc_next;
          end
        end
        S_REQ_HI: begin
          if (mem_ack) begin
            r_bus_data <= mem_rdata;
            r_pc       <= w_pc_next;
            r_mem_req  <= 1'b0;
            r_ld_j1    <= 1'b1;
            r_state    <= S_LD_HI;
          end
        end
        S_LD_HI: begin
          r_mem_addr <= r_pc;
          r_mem_req  <= 1'b1;
          r_state    <= S_REQ_LO;
        end
        S_REQ_LO: begin
          if (mem_ack) begin
            r_j2      <= mem_rdata;
            r_pc      <= w_pc_next;
            r_mem_req <= 1'b0;
            r_state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          // J1 was loaded two edges ago, so j1_content is settled here.
          if (w_taken) begin
            r_pc <= {j1_content, r_j2};
            if (r_call) begin
              r_xy_data <= r_pc;
              r_xy_we   <= 1'b1;
            end
          end
          r_done  <= 1'b1;
          r_taken <= w_taken;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_req   = r_mem_req;
  assign bus_data  = r_bus_data;
  assign ld_j1     = r_ld_j1;
  assign pc        = r_pc;
  assign xy_data   = r_xy_data;
  assign xy_we     = r_xy_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign taken     = r_taken;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jump_addr_sequencer.sv
// Bench for jump_addr_sequencer: directed GOTO/CALL vectors with a memory and J1 model,
// expected results queued by the driver and checked by independent monitors.
module tb_jump_addr_sequencer;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_inc = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    cond = 4'b0000;
  logic          call = 1'b0;
  logic          flag_s = 1'b0;
  logic          flag_c = 1'b0;
  logic          flag_z = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] bus_data;
  logic          ld_j1;
  logic [DW-1:0] j1_content = '0;
  logic [AW-1:0] pc;
  logic [AW-1:0] xy_data;
  logic          xy_we;
  logic          busy;
  logic          done;
  logic          taken;
  logic [2:0]    dbg_state;

  jump_addr_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .start(start), .cond(cond), .call(call),
    .flag_s(flag_s), .flag_c(flag_c), .flag_z(flag_z),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_data(bus_data), .ld_j1(ld_j1), .j1_content(j1_content), .pc(pc),
    .xy_data(xy_data), .xy_we(xy_we), .busy(busy), .done(done), .taken(taken),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model: two operand bytes, programmable wait ----------------
  logic [AW-1:0] op_addr = '0;
  logic [AW-1:0] op_addr_lo = 16'h0001;
  logic [DW-1:0] op_hi = '0;
  logic [DW-1:0] op_lo = '0;
  int            wait_cfg = 0;
  int            wcnt = 0;

  assign mem_ack   = mem_req && (wcnt == wait_cfg);
  assign mem_rdata = (mem_addr == op_addr) ? op_hi :
                     (mem_addr == op_addr_lo) ? op_lo : 8'hEE;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // J1 register model (not cleared by reset)
  always @(posedge clk) if (ld_j1) j1_content <= bus_data;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  int start_cyc = 0;

  logic [41:0]   exp_q[$];   // {taken, pc, xy_we, xy_data, latency}
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] bus_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (mem_req && prev_wait) check("mem_addr_hold", mem_addr, prev_addr);
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;

      if (mem_req && mem_ack) begin
        if (addr_q.size() == 0) check("mem_read_unexpected", addr_q.size(), 1);
        else check("mem_addr", mem_addr, addr_q.pop_front());
      end

      if (ld_j1) begin
        if (bus_q.size() == 0) check("ld_j1_unexpected", bus_q.size(), 1);
        else check("bus_data_at_ld_j1", bus_data, bus_q.pop_front());
      end

      if (xy_we) check("xy_we_with_done", done, 1);

      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", exp_q.size(), 1);
        end else begin
          logic [41:0] e;
          e = exp_q.pop_front();
          check("taken", taken, e[41]);
          check("pc_after_done", pc, e[40:25]);
          check("xy_we", xy_we, e[24]);
          if (e[24]) check("xy_data", xy_data, e[23:8]);
          check("latency", cyc - start_cyc, e[7:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [15:0] at;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [3:0]  c;
    logic        cl;
    logic        fs;
    logic        fc;
    logic        fz;
    int          waits;
    logic        et;
    logic [15:0] epc;
    logic        ewe;
    logic [15:0] exy;
    int          lat;
    logic        poke;
  } vec_t;

  task automatic run_instr(input vec_t v);
    logic got;
    @(negedge clk);
    check("pc_before_start", pc, v.at);
    op_addr    = v.at;
    op_addr_lo = v.at + 16'd1;
    op_hi      = v.hi;
    op_lo      = v.lo;
    wait_cfg   = v.waits;
    flag_s     = v.fs;
    flag_c     = v.fc;
    flag_z     = v.fz;
    cond       = v.c;
    call       = v.cl;
    addr_q.push_back(v.at);
    addr_q.push_back(op_addr_lo);
    bus_q.push_back(v.hi);
    exp_q.push_back({v.et, v.epc, v.ewe, v.exy, 8'(v.lat)});
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    cond  = ~v.c;   // must have been latched at start
    call  = ~v.cl;
    if (v.poke) begin
      @(negedge clk);
      start  = 1'b1;
      pc_inc = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      pc_inc = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("done_timeout", got, 1);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{16'h0010, 8'h12, 8'h34, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h1234, 1'b0, 16'h0000, 4, 1'b0};
    vecs[1]  = '{16'h1234, 8'h00, 8'h10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0010, 1'b0, 16'h0000, 4, 1'b0};
    vecs[2]  = '{16'h0010, 8'h12, 8'h34, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h0012, 1'b0, 16'h0000, 4, 1'b0};
    vecs[3]  = '{16'h0012, 8'h00, 8'h10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0010, 1'b0, 16'h0000, 4, 1'b0};
    vecs[4]  = '{16'h0010, 8'h12, 8'h34, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 16'h1234, 1'b0, 16'h0000, 4, 1'b0};
    vecs[5]  = '{16'h1234, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0100, 1'b0, 16'h0000, 4, 1'b0};
    vecs[6]  = '{16'h0100, 8'hAB, 8'hCD, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'hABCD, 1'b1, 16'h0102, 4, 1'b0};
    vecs[7]  = '{16'hABCD, 8'h55, 8'h66, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 16'h5566, 1'b0, 16'h0000, 10, 1'b1};
    vecs[8]  = '{16'h5566, 8'hFF, 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 4, 1'b0};
    vecs[9]  = '{16'hFFFF, 8'h00, 8'h40, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0040, 1'b0, 16'h0000, 4, 1'b0};
    vecs[10] = '{16'h0040, 8'hFF, 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 6, 1'b0};
    vecs[11] = '{16'hFFFF, 8'h00, 8'h40, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 16'h0001, 1'b0, 16'h0000, 4, 1'b0};
    vecs[12] = '{16'h0001, 8'h12, 8'h34, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 16'h0003, 1'b0, 16'h0000, 4, 1'b0};
    vecs[13] = '{16'h0003, 8'h77, 8'h88, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 16'h7788, 1'b1, 16'h0005, 4, 1'b0};
    vecs[14] = '{16'h7788, 8'h00, 8'h10, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 16'h0010, 1'b0, 16'h0000, 8, 1'b0};
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_bus_data"}, bus_data, 0);
    check({tag, "_ld_j1"}, ld_j1, 0);
    check({tag, "_xy_data"}, xy_data, 0);
    check({tag, "_xy_we"}, xy_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_taken"}, taken, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic reached;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_inc = 1'b1;
      @(negedge clk);
      pc_inc = 1'b0;
    end
    check("pc_after_3_inc", pc, 16'h0003);

    // abort an instruction while it waits in REQ_LO
    op_addr = 16'h0003; op_addr_lo = 16'h0004; op_hi = 8'h5A; op_lo = 8'hA5; wait_cfg = 2;
    addr_q.push_back(16'h0003);
    bus_q.push_back(8'h5A);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd3) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_req_lo", reached, 1);
    check("bus_data_before_abort", bus_data, 8'h5A);
    check("mem_req_in_req_lo", mem_req, 1);
    check("pc_in_req_lo", pc, 16'h0004);
    rst_n = 1'b0;
    #1 check_all_zero("abort");
    addr_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    pc_inc = 1'b1;
    repeat (16) @(negedge clk);
    pc_inc = 1'b0;
    check("pc_after_16_inc", pc, 16'h0010);

    for (int i = 0; i < 15; i++) run_instr(vecs[i]);

    repeat (4) @(negedge clk);
    check("busy_idle_at_end", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
